// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle fetch/decode/execute/writeback controller that feeds
// a 16-bit, 8-operation combinational ALU. Holds PC, IR and an 8x16 register file.
module ctrl_unit #(
   parameter int DATA_WIDTH     = 16,
   parameter int SEL_OPERATION  = 3,
   parameter int PC_WIDTH       = 8,
   parameter int REG_ADDR_WIDTH = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   output logic                      imem_req_o,
   output logic [PC_WIDTH-1:0]       imem_addr_o,
   input  logic [DATA_WIDTH-1:0]     imem_data_i,
   input  logic                      imem_valid_i,
   output logic [DATA_WIDTH-1:0]     alu_a_o,
   output logic [DATA_WIDTH-1:0]     alu_b_o,
   output logic [SEL_OPERATION-1:0]  alu_sel_o,
   input  logic [DATA_WIDTH-1:0]     alu_result_i,
   output logic                      wb_en_o,
   output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
   output logic [DATA_WIDTH-1:0]     wb_data_o,
   output logic [PC_WIDTH-1:0]       pc_o,
   output logic                      halted_o
);

   localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

   state_t                    state, state_nxt;
   logic [PC_WIDTH-1:0]       pc, pc_nxt;
   logic [DATA_WIDTH-1:0]     ir;
   logic [DATA_WIDTH-1:0]     result;
   logic [REG_ADDR_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0]     rf [NUM_REGS];

   // Instruction fields (fixed 16-bit encoding)
   logic [3:0]                op;
   logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
   logic [DATA_WIDTH-1:0]     imm9;
   logic [PC_WIDTH-1:0]       target;
   logic                      is_alu, is_ldi, is_jmp, is_beqz, is_halt, writes_rd;
   logic [DATA_WIDTH-1:0]     rs1_val, rs2_val, rd_val;

   assign op      = ir[15:12];
   assign rd      = ir[11:9];
   assign rs1     = ir[8:6];
   assign rs2     = ir[5:3];
   assign imm9    = {{(DATA_WIDTH-9){1'b0}}, ir[8:0]};
   assign target  = ir[PC_WIDTH-1:0];
   assign is_alu  = ~op[3];
   assign is_ldi  = (op == 4'b1000);
   assign is_jmp  = (op == 4'b1001);
   assign is_beqz = (op == 4'b1010);
   assign is_halt = (op == 4'b1111);
   assign writes_rd = is_alu | is_ldi;

   // r0 reads as zero regardless of storage contents
   assign rs1_val = (rs1 == '0) ? '0 : rf[rs1];
   assign rs2_val = (rs2 == '0) ? '0 : rf[rs2];
   assign rd_val  = (rd  == '0) ? '0 : rf[rd];

   assign imem_addr_o = pc;
   assign pc_o        = pc;
   assign wb_addr_o   = wb_addr;
   assign wb_data_o   = result;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // Next-state, Moore outputs and next PC
   always_comb begin
      state_nxt  = state;
      imem_req_o = 1'b0;
      halted_o   = 1'b0;
      wb_en_o    = 1'b0;
      pc_nxt     = pc + PC_WIDTH'(1);
      if (is_jmp || (is_beqz && rd_val == '0)) pc_nxt = target;
      case (state)
         S_FETCH: begin
            imem_req_o = 1'b1;
            if (imem_valid_i) state_nxt = S_DECODE;
         end
         S_DECODE:    state_nxt = is_halt ? S_HALT : S_EXECUTE;
         S_EXECUTE:   state_nxt = S_WRITEBACK;
         S_WRITEBACK: begin
            wb_en_o   = writes_rd;
            state_nxt = S_FETCH;
         end
         S_HALT:      halted_o = 1'b1;
         default:     state_nxt = S_FETCH;
      endcase
   end

   // Datapath: IR capture, operand staging, result capture, PC update
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc        <= '0;
         ir        <= '0;
         result    <= '0;
         wb_addr   <= '0;
         alu_a_o   <= '0;
         alu_b_o   <= '0;
         alu_sel_o <= '0;
      end else begin
         case (state)
            S_FETCH: if (imem_valid_i) ir <= imem_data_i;
            S_DECODE: begin
               if (is_alu) begin
                  alu_a_o   <= rs1_val;
                  alu_b_o   <= rs2_val;
                  alu_sel_o <= op[SEL_OPERATION-1:0];
               end else begin
                  alu_a_o   <= '0;
                  alu_b_o   <= '0;
                  alu_sel_o <= '0;
               end
            end
            S_EXECUTE: begin
               // result/wb_addr only move for writing ops so they hold otherwise
               if (writes_rd) begin
                  result  <= is_alu ? alu_result_i : imm9;
                  wb_addr <= rd;
               end
            end
            S_WRITEBACK: pc <= pc_nxt;
            default: ;
         endcase
      end
   end

   // Register file write; r0 writes are dropped
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (wb_en_o && wb_addr != '0) begin
         rf[wb_addr] <= result;
      end
   end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
Multi-cycle fetch/decode/execute/writeback controller that sits directly upstream of the 16-bit, 8-operation ALU. It holds the program counter, the instruction register and an 8x16 register file. It fetches over a request/valid handshake, drives registered ALU operands and select, captures the combinational ALU result and writes it back. It also implements load-immediate, jump, branch-if-zero and halt.

Parameters:
DATA_WIDTH, 16, register/ALU data width (instruction width is also 16).
SEL_OPERATION, 3, ALU select width.
PC_WIDTH, 8, program counter / instruction address width.
REG_ADDR_WIDTH, 3, register index width (8 registers).

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  synchronous, active-high reset.
imem_req_o  output  1  fetch request, high while in FETCH.
imem_addr_o  output  PC_WIDTH  fetch address (= PC).
imem_data_i  input  DATA_WIDTH  instruction word, valid when imem_valid_i=1.
imem_valid_i  input  1  instruction return strobe; sampled only in FETCH.
alu_a_o  output  DATA_WIDTH  ALU operand A (registered).
alu_b_o  output  DATA_WIDTH  ALU operand B (registered).
alu_sel_o  output  SEL_OPERATION  ALU operation select (registered).
alu_result_i  input  DATA_WIDTH  combinational ALU result.
wb_en_o  output  1  register-file write strobe (observability).
wb_addr_o  output  REG_ADDR_WIDTH  destination register.
wb_data_o  output  DATA_WIDTH  write-back data.
pc_o  output  PC_WIDTH  current PC.
halted_o  output  1  high in HALT.

Behaviour:
- Instruction fields: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3].
- op 0xxx: ALU op, sel=op[2:0] (000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 sll, 111 srl); rd <= ALU(rf[rs1], rf[rs2]). NOT ignores rs2.
- 1000 LDI: rd <= zero-extended [8:0].
- 1001 JMP: PC <= [7:0].
- 1010 BEQZ: if rf[[11:9]]==0 then PC <= [7:0], else PC+1.
- 1111 HALT.
- 1011..1110: NOP (PC+1).
- r0 always reads 0; writes to r0 are dropped (wb_en_o still pulses with wb_addr_o=0).
- FSM states: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALT is terminal.
- FETCH: imem_req_o=1, imem_addr_o=PC. Stay in FETCH until imem_valid_i=1, then latch imem_data_i into IR and go to DECODE. Zero-wait (valid in the first FETCH cycle) is legal.
- DECODE: register alu_a_o<=rf[rs1], alu_b_o<=rf[rs2], alu_sel_o<=op[2:0] for ALU ops. For non-ALU ops, operands <= 0 and sel <= 000. HALT goes to HALT instead of EXECUTE.
- EXECUTE: capture alu_result_i (ALU op) or zero-extended imm9 (LDI) into the result register.
- WRITEBACK (single cycle):
  - ALU/LDI: wb_en_o=1, wb_addr_o=rd, wb_data_o=result, rf[rd] written at the end of the cycle.
  - JMP/BEQZ/NOP: wb_en_o=0.
  - PC updated at the end of the cycle.
- Latency: 4 cycles per instruction plus fetch wait cycles.
- PC increments modulo 2^PC_WIDTH (0xFF+1 -> 0x00).
- HALT: halted_o=1, imem_req_o=0; only rst_i exits.
- wb_en_o, imem_req_o and halted_o are Moore outputs decoded from state. wb_addr_o/wb_data_o hold the last values when wb_en_o=0.
- Reset (any state, including mid-fetch or mid-execute): state=FETCH, PC=0, IR=0, all registers=0, result=0, alu_a_o=alu_b_o=0, alu_sel_o=0, wb_en_o=0, wb_addr_o=0, wb_data_o=0, halted_o=0. imem_req_o=1 and imem_addr_o=0 in the first cycle after reset. No write-back from an interrupted instruction.
- A late imem_valid_i arriving after reset is ignored unless the block is in FETCH. The first post-reset valid in FETCH is accepted.

Test Plan:
- Program 0x8205, 0x8403, 0x1650 (LDI r1,5; LDI r2,3; SUB r3,r1,r2), zero-wait fetch -> wb pulses (1,0x0005),(2,0x0003),(3,0x0002) at cycles 4, 8, 12 after reset release; pc_o=3.
- Continue with 0x6850 (SLL r4,r1,r2), 0xA010 (BEQZ r0,0x10), then 0xF000 at address 0x10 -> wb (4,0x0028); pc_o=0x10; halted_o=1, imem_req_o=0 and held for 20 cycles.
- Fetch wait states: imem_valid_i delayed 3 cycles on every fetch for the first program -> identical wb sequence; each instruction takes 7 cycles; IR unchanged while waiting.
- 0x8007 (LDI r0,7), then 0x0A00 (ADD r5,r0,r0) -> first wb_addr_o=0; second wb (5,0x0000); alu_a_o=alu_b_o=0.
- JMP 0xFF (0x90FF) followed by NOP 0xB000 at 0xFF -> pc_o=0xFF then 0x00 (wrap).
- rst_i=1 for one cycle during EXECUTE of SUB -> no wb pulse; next cycle imem_req_o=1, imem_addr_o=0; all outputs at reset values; rerun yields the first scenario exactly.
